bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Two-requester arbiter for a shared data path, with registered grants and select.
// Ties go to the requester not granted last, and a bounded hold forces rotation under contention.
module bus_arbiter #(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] out,
  output logic             valid
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT_A = 2'd1;
  localparam logic [1:0] ST_GNT_B = 2'd2;
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;
  logic       sel_q, sel_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic       gnt_a_q, gnt_a_d;
  logic       gnt_b_q, gnt_b_d;

  // Next-state selection, then bookkeeping for grant entry and hold counting.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    sel_d      = sel_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_a && req_b) begin
          state_d = last_q ? ST_GNT_A : ST_GNT_B;
        end else if (req_a) begin
          state_d = ST_GNT_A;
        end else if (req_b) begin
          state_d = ST_GNT_B;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GNT_A: begin
        if (!req_a) begin
          state_d = req_b ? ST_GNT_B : ST_IDLE;
        end else if (req_b && (hold_cnt_q == HOLD_LAST)) begin
          state_d = ST_GNT_B;
        end else begin
          state_d = ST_GNT_A;
        end
      end
      ST_GNT_B: begin
        if (!req_b) begin
          state_d = req_a ? ST_GNT_A : ST_IDLE;
        end else if (req_a && (hold_cnt_q == HOLD_LAST)) begin
          state_d = ST_GNT_A;
        end else begin
          state_d = ST_GNT_B;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A grant entry (from IDLE or a direct handoff) restarts the hold and moves sel with it.
    if ((state_d != state_q) && (state_d != ST_IDLE)) begin
      hold_cnt_d = 4'd0;
      last_d     = (state_d == ST_GNT_B);
      sel_d      = (state_d == ST_GNT_B);
    end else if (state_d != ST_IDLE) begin
      if (hold_cnt_q != HOLD_LAST) begin
        hold_cnt_d = hold_cnt_q + 4'd1;
      end else begin
        hold_cnt_d = hold_cnt_q;
      end
    end else begin
      hold_cnt_d = 4'd0;
    end

    gnt_a_d = (state_d == ST_GNT_A);
    gnt_b_d = (state_d == ST_GNT_B);
  end

  // State and output registers; last resets to B so that A wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      sel_q      <= 1'b0;
      hold_cnt_q <= 4'd0;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_a_q    <= gnt_a_d;
      gnt_b_q    <= gnt_b_d;
    end
  end

  assign gnt_a = gnt_a_q;
  assign gnt_b = gnt_b_q;
  assign sel   = sel_q;
  assign valid = gnt_a_q | gnt_b_q;
  assign out   = sel_q ? b_data : a_data;

endmodule
